coherent_integrator: RTL

Multi-channel coherent pulse integrator for the radar receive path. Each trigger starts a record of up to DEPTH complex samples per channel. Each sample is added bin-by-bin into block-RAM accumulators. An integration-start trigger streams out the previous sum, rounded and scaled down by a run-time shift, and reseeds the accumulators with the new pulse. It is the next generation of the single-channel I/Q accumulator: the channel count, widths and record length are parametrised, the rounding and saturation are defined, and it adds overflow flagging and read-after-write forwarding.

---
 rtl/coherent_integrator.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/coherent_integrator.sv
`default_nettype none
// ============================================================================
// Module   : coherent_integrator
// Purpose  : Multi-channel coherent pulse integrator with RAM accumulators,
//            rounded/scaled dump on seed and sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module coherent_integrator #(
    parameter int NCH   = 2,
    parameter int DW    = 16,
    parameter int AW    = 28,
    parameter int DEPTH = 4096,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic              trig_int,
    input  logic [4:0]        shift,
    input  logic [LW-1:0]     len,
    input  logic [NCH*DW-1:0] din_I,
    input  logic [NCH*DW-1:0] din_Q,
    output logic [NCH*DW-1:0] dout_I,
    output logic [NCH*DW-1:0] dout_Q,
    output logic              dout_vld,
    output logic [LW-1:0]     dout_idx,
    output logic              busy,
    output logic              ovf
);
    localparam int c_LANES = 2 * NCH;
    localparam int c_ADW   = $clog2(DEPTH);
    localparam int c_MW    = c_LANES * AW;
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;
    localparam logic signed [AW:0] c_ACC_MAX = {2'b00, {(AW-1){1'b1}}};
    localparam logic signed [AW:0] c_ACC_MIN = {2'b11, {(AW-1){1'b0}}};
    localparam logic signed [AW:0] c_OUT_MAX = {{(AW+2-DW){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW:0] c_OUT_MIN = {{(AW+2-DW){1'b1}}, {(DW-1){1'b0}}};

    logic [0:0]    r_state;
    logic [LW-1:0] r_k, r_len;
    logic [4:0]    r_shift;
    logic          r_seed, r_emit, r_have_base;

    logic [LW-1:0] w_len_eff, w_s0_k;
    logic [4:0]    w_s0_shift;
    logic          w_trig_seed, w_s0_vld, w_s0_seed, w_s0_emit, w_s0_first;

    always_comb begin
        w_len_eff = len;
        if (len == '0 || len > LW'(DEPTH)) w_len_eff = LW'(DEPTH);
    end

    assign w_trig_seed = trig_int | ~r_have_base;
    assign w_s0_vld    = trig | (r_state == c_RUN);
    assign w_s0_k      = trig ? '0 : r_k;
    assign w_s0_seed   = trig ? w_trig_seed : r_seed;
    assign w_s0_emit   = trig ? (w_trig_seed & r_have_base) : r_emit;
    assign w_s0_shift  = trig ? shift : r_shift;
    assign w_s0_first  = trig & w_trig_seed;
    assign busy        = (r_state == c_RUN);

    // Record sequencer; a trig always wins and restarts at bin 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_k         <= '0;
            r_len       <= '0;
            r_shift     <= '0;
            r_seed      <= 1'b0;
            r_emit      <= 1'b0;
            r_have_base <= 1'b0;
        end else if (trig) begin
            r_len   <= w_len_eff;
            r_shift <= shift;
            r_seed  <= w_trig_seed;
            r_emit  <= w_trig_seed & r_have_base;
            if (w_trig_seed) r_have_base <= 1'b1;
            r_k     <= LW'(1);
            r_state <= (w_len_eff == LW'(1)) ? c_IDLE : c_RUN;
        end else begin
            case (r_state)
                c_RUN: begin
                    if (r_k == r_len - LW'(1)) r_state <= c_IDLE;
                    r_k <= r_k + LW'(1);
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    logic [c_MW-1:0]         r_mem [DEPTH];
    logic [c_MW-1:0]         r_rd_data;
    logic                    r_s1_vld, r_s1_seed, r_s1_emit, r_s1_first;
    logic [LW-1:0]           r_s1_k;
    logic [4:0]              r_s1_shift;
    logic [c_LANES*DW-1:0]   r_s1_din;
    logic                    r_s2_vld, r_s2_emit;
    logic [LW-1:0]           r_s2_k;
    logic [4:0]              r_s2_shift;
    logic [c_MW-1:0]         r_s2_val, r_s2_old;
    logic                    r_s3_vld, r_s3_emit;
    logic [LW-1:0]           r_s3_k;
    logic [c_MW-1:0]         r_s3_val;
    logic [c_LANES*(AW+1)-1:0] r_s3_scaled;

    always_ff @(posedge clk) begin
        r_rd_data <= r_mem[w_s0_k[c_ADW-1:0]];
        if (r_s2_vld) r_mem[r_s2_k[c_ADW-1:0]] <= r_s2_val;
    end

    always_ff @(posedge clk) begin
        if (rst) r_s1_vld <= 1'b0;
        else     r_s1_vld <= w_s0_vld;
        r_s1_k     <= w_s0_k;
        r_s1_seed  <= w_s0_seed;
        r_s1_emit  <= w_s0_emit;
        r_s1_first <= w_s0_first;
        r_s1_shift <= w_s0_shift;
        r_s1_din   <= {din_Q, din_I};
    end

    // Stage 1: the two youngest writes are not yet visible in RAM data.
    logic [c_MW-1:0]   w_old, w_new;
    logic signed [AW:0] w_dx, w_sum;
    logic              w_sat_any;
    always_comb begin
        w_old = r_rd_data;
        if (r_s2_vld && r_s2_k == r_s1_k)      w_old = r_s2_val;
        else if (r_s3_vld && r_s3_k == r_s1_k) w_old = r_s3_val;
        w_new     = '0;
        w_sat_any = 1'b0;
        w_dx      = '0;
        w_sum     = '0;
        for (int l = 0; l < c_LANES; l++) begin
            w_dx  = (AW+1)'($signed(r_s1_din[l*DW +: DW]));
            w_sum = (AW+1)'($signed(w_old[l*AW +: AW])) + w_dx;
            if (r_s1_seed) begin
                w_new[l*AW +: AW] = w_dx[AW-1:0];
            end else if (w_sum > c_ACC_MAX) begin
                w_new[l*AW +: AW] = c_ACC_MAX[AW-1:0];
                w_sat_any = 1'b1;
            end else if (w_sum < c_ACC_MIN) begin
                w_new[l*AW +: AW] = c_ACC_MIN[AW-1:0];
                w_sat_any = 1'b1;
            end else begin
                w_new[l*AW +: AW] = w_sum[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld  <= 1'b0;
            r_s2_emit <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            r_s2_vld  <= r_s1_vld;
            r_s2_emit <= r_s1_vld & r_s1_emit;
            if (r_s1_vld && r_s1_first)     ovf <= 1'b0;
            else if (r_s1_vld && w_sat_any) ovf <= 1'b1;
        end
        r_s2_k     <= r_s1_k;
        r_s2_shift <= r_s1_shift;
        r_s2_val   <= w_new;
        r_s2_old   <= w_old;
    end

    logic signed [AW:0]        w_rnd, w_tmp;
    logic [c_LANES*(AW+1)-1:0] w_scaled;
    always_comb begin
        w_rnd = '0;
        if (r_s2_shift != 5'd0) w_rnd = (AW+1)'(1) << (r_s2_shift - 5'd1);
        w_tmp    = '0;
        w_scaled = '0;
        for (int l = 0; l < c_LANES; l++) begin
            w_tmp = (AW+1)'($signed(r_s2_old[l*AW +: AW])) + w_rnd;
            w_scaled[l*(AW+1) +: AW+1] = w_tmp >>> r_s2_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_vld  <= 1'b0;
            r_s3_emit <= 1'b0;
        end else begin
            r_s3_vld  <= r_s2_vld;
            r_s3_emit <= r_s2_vld & r_s2_emit;
        end
        r_s3_k      <= r_s2_k;
        r_s3_val    <= r_s2_val;
        r_s3_scaled <= w_scaled;
    end

    logic signed [AW:0]    w_v;
    logic [c_LANES*DW-1:0] w_out;
    always_comb begin
        w_v   = '0;
        w_out = '0;
        for (int l = 0; l < c_LANES; l++) begin
            w_v = r_s3_scaled[l*(AW+1) +: AW+1];
            if (w_v > c_OUT_MAX)      w_out[l*DW +: DW] = c_OUT_MAX[DW-1:0];
            else if (w_v < c_OUT_MIN) w_out[l*DW +: DW] = c_OUT_MIN[DW-1:0];
            else                      w_out[l*DW +: DW] = w_v[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_vld <= 1'b0;
            dout_idx <= '0;
            dout_I   <= '0;
            dout_Q   <= '0;
        end else begin
            dout_vld <= r_s3_emit;
            if (r_s3_emit) begin
                dout_idx         <= r_s3_k;
                {dout_Q, dout_I} <= w_out;
            end
        end
    end
endmodule
`default_nettype wire
